// File: rtl/alu_mdu.sv
// alu_mdu: registered single-cycle ALU operations plus an iterative radix-2
// multiply/divide unit (signed and unsigned) with HI/LO results and a
// start/busy/done handshake.
module alu_mdu #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             start,
  input  logic [4:0]       aluc,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] s,
  output logic             z,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             dz
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCalc = 2'd1;
  localparam logic [1:0] StFix  = 2'd2;

  // Control state
  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // Datapath: acc holds product high half / partial remainder,
  // mq holds multiplier -> product low half / dividend -> quotient.
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mq_q, mq_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic             div_q, div_d;
  logic             neg_lo_q, neg_lo_d;
  logic             neg_hi_q, neg_hi_d;
  logic             dzp_q, dzp_d;
  // Registered outputs
  logic [WIDTH-1:0] s_q, s_d;
  logic             z_q, z_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;

  logic [WIDTH-1:0] legacy_res;
  logic             is_mdu;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] fix_hi, fix_lo;

  assign is_mdu = (aluc[4:2] == 3'b100);
  assign a_neg  = aluc[0] & a[WIDTH-1];
  assign b_neg  = aluc[0] & b[WIDTH-1];
  assign a_mag  = a_neg ? -a : a;
  assign b_mag  = b_neg ? -b : b;

  // Single-cycle ALU result; encodings outside the table yield zero
  always_comb begin
    legacy_res = '0;
    casez (aluc)
      5'b0?000: legacy_res = a + b;
      5'b0?100: legacy_res = a - b;
      5'b0?001: legacy_res = a & b;
      5'b0?101: legacy_res = a | b;
      5'b0?010: legacy_res = a ^ b;
      5'b0?110: legacy_res = a << (WIDTH / 2);
      5'b00011: legacy_res = b << a[SW-1:0];
      5'b00111: legacy_res = b >> a[SW-1:0];
      5'b01111: legacy_res = $unsigned($signed(b) >>> a[SW-1:0]);
      5'b01011: legacy_res = {{(WIDTH-1){1'b0}}, (a > b)};
      default:  legacy_res = '0;
    endcase
  end

  // One radix-2 step: shift-add multiply and restoring divide
  always_comb begin
    addend  = mq_q[0] ? mcand_q : '0;
    mul_sum = {1'b0, acc_q} + {1'b0, addend};
    trial   = {acc_q, mq_q[WIDTH-1]};
    // Borrow in bit WIDTH means the divisor did not fit
    diff    = trial - {1'b0, mcand_q};
  end

  // Sign correction of the magnitude results
  always_comb begin
    prod   = {acc_q, mq_q};
    fix_hi = acc_q;
    fix_lo = mq_q;
    if (div_q) begin
      fix_lo = neg_lo_q ? -mq_q : mq_q;
      fix_hi = neg_hi_q ? -acc_q : acc_q;
    end else if (neg_lo_q) begin
      prod = -prod;
      {fix_hi, fix_lo} = prod;
    end
  end

  // FSM and datapath next-state
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mq_d     = mq_q;
    mcand_d  = mcand_q;
    div_d    = div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    dzp_d    = dzp_q;
    s_d      = s_q;
    z_d      = z_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    dz_d     = dz_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          if (is_mdu) begin
            busy_d   = 1'b1;
            div_d    = aluc[1];
            cnt_d    = '0;
            acc_d    = '0;
            mq_d     = a_mag;
            mcand_d  = b_mag;
            neg_lo_d = a_neg ^ b_neg;
            // Remainder follows the dividend; a product only needs neg_lo
            neg_hi_d = aluc[1] ? a_neg : (a_neg ^ b_neg);
            if (aluc[1] && (b == '0)) begin
              // Divide by zero: preload the final results, skip iteration
              acc_d    = a;
              mq_d     = '1;
              neg_lo_d = 1'b0;
              neg_hi_d = 1'b0;
              dzp_d    = 1'b1;
              state_d  = StFix;
            end else begin
              dzp_d   = 1'b0;
              state_d = StCalc;
            end
          end else begin
            s_d    = legacy_res;
            z_d    = (legacy_res == '0);
            done_d = 1'b1;
            dz_d   = 1'b0;
          end
        end
      end
      StCalc: begin
        cnt_d = cnt_q + CW'(1);
        if (div_q) begin
          acc_d = diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
          mq_d  = {mq_q[WIDTH-2:0], ~diff[WIDTH]};
        end else begin
          acc_d = mul_sum[WIDTH:1];
          mq_d  = {mul_sum[0], mq_q[WIDTH-1:1]};
        end
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = StFix;
        end
      end
      StFix: begin
        hi_d    = fix_hi;
        lo_d    = fix_lo;
        s_d     = fix_lo;
        z_d     = (fix_lo == '0);
        dz_d    = dzp_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  // State registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      mq_q     <= '0;
      mcand_q  <= '0;
      div_q    <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      dzp_q    <= 1'b0;
      s_q      <= '0;
      z_q      <= 1'b1;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mq_q     <= mq_d;
      mcand_q  <= mcand_d;
      div_q    <= div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      dzp_q    <= dzp_d;
      s_q      <= s_d;
      z_q      <= z_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
    end
  end

  assign s    = s_q;
  assign z    = z_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = busy_q;
  assign done = done_q;
  assign dz   = dz_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Directed testbench for alu_mdu: legacy ops, mul/div, divide by zero,
// handshake hazards, and a WIDTH=8 instance checked against a reference model.
module tb_alu_mdu;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic        start;
  logic [4:0]  aluc;
  logic [31:0] a, b, s, hi, lo;
  logic        z, busy, done, dz;

  logic        start8;
  logic [4:0]  aluc8;
  logic [7:0]  a8, b8, s8, hi8, lo8;
  logic        z8, busy8, done8, dz8;

  int n_cmp = 0;
  int n_err = 0;
  int lat;
  int busy_cnt;
  logic got;

  always #5 clk = ~clk;

  alu_mdu #(.WIDTH(32)) dut (
    .clk(clk), .clrn(clrn), .start(start), .aluc(aluc), .a(a), .b(b),
    .s(s), .z(z), .hi(hi), .lo(lo), .busy(busy), .done(done), .dz(dz)
  );

  alu_mdu #(.WIDTH(8)) dut8 (
    .clk(clk), .clrn(clrn), .start(start8), .aluc(aluc8), .a(a8), .b(b8),
    .s(s8), .z(z8), .hi(hi8), .lo(lo8), .busy(busy8), .done(done8), .dz(dz8)
  );

  // Issue one op on the 32-bit DUT; lat = edges after the accepting edge until done
  task automatic run_op(input logic [4:0] op, input logic [31:0] opa, input logic [31:0] opb);
    @(negedge clk);
    start = 1'b1; aluc = op; a = opa; b = opb;
    @(posedge clk); #1;
    start = 1'b0; aluc = 5'h1f; a = ~opa; b = ~opb;
    lat = 0; busy_cnt = 0;
    while (!done && lat < 100) begin
      if (busy) busy_cnt++;
      @(posedge clk); #1;
      lat++;
    end
    got = done;
  endtask

  task automatic run_op8(input logic [4:0] op, input logic [7:0] opa, input logic [7:0] opb);
    @(negedge clk);
    start8 = 1'b1; aluc8 = op; a8 = opa; b8 = opb;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = ~opa; b8 = ~opb;
    lat = 0;
    while (!done8 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    got = done8;
  endtask

  // Reference {hi, lo} for WIDTH=8 using native arithmetic
  function automatic logic [15:0] ref8(input logic [4:0] op, input logic [7:0] x,
                                       input logic [7:0] y);
    int sx, sy, ux, uy, p, q, r;
    sx = $signed(x); sy = $signed(y);
    ux = int'(x);    uy = int'(y);
    case (op[1:0])
      2'b00: p = ux * uy;
      2'b01: p = sx * sy;
      default: p = 0;
    endcase
    if (!op[1]) return p[15:0];
    if (y == 8'h00) return {x, 8'hff};
    if (op[0]) begin q = sx / sy; r = sx % sy; end
    else begin q = ux / uy; r = ux % uy; end
    return {r[7:0], q[7:0]};
  endfunction

  task automatic test_reset();
    #12;
    n_cmp++; if (s !== 32'h0)  begin $display("FAIL reset_s: got %h want 0", s); n_err++; end
    n_cmp++; if (z !== 1'b1)   begin $display("FAIL reset_z: got %b want 1", z); n_err++; end
    n_cmp++; if ({hi, lo} !== 64'h0) begin
      $display("FAIL reset_hilo: got %h want 0", {hi, lo}); n_err++;
    end
    n_cmp++; if ({busy, done, dz} !== 3'b000) begin
      $display("FAIL reset_flags: got %b want 000", {busy, done, dz}); n_err++;
    end
    @(negedge clk); clrn = 1'b1;
  endtask

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
  } lvec_t;

  task automatic test_legacy();
    lvec_t v[$];
    v.push_back('{5'h04, 32'd5,        32'd5,        32'h0000_0000}); // SUB
    v.push_back('{5'h0f, 32'd4,        32'h8000_0000, 32'hf800_0000}); // SRA
    v.push_back('{5'h00, 32'hffff_ffff, 32'd2,        32'h0000_0001}); // ADD wraps
    v.push_back('{5'h01, 32'hf0f0_1234, 32'h0ff0_ffff, 32'h00f0_1234}); // AND
    v.push_back('{5'h0d, 32'hf000_0000, 32'h0000_000f, 32'hf000_000f}); // OR
    v.push_back('{5'h02, 32'hffff_0000, 32'h0f0f_0f0f, 32'hf0f0_0f0f}); // XOR
    v.push_back('{5'h0e, 32'h0000_abcd, 32'h1234_5678, 32'habcd_0000}); // a << 16
    v.push_back('{5'h03, 32'd4,        32'h0000_00f1, 32'h0000_0f10}); // SLL
    v.push_back('{5'h07, 32'd4,        32'h8000_0000, 32'h0800_0000}); // SRL
    v.push_back('{5'h0b, 32'hffff_ffff, 32'd1,        32'h0000_0001}); // GTU true
    v.push_back('{5'h0b, 32'd1,        32'd2,        32'h0000_0000}); // GTU false
    v.push_back('{5'h14, 32'd5,        32'd6,        32'h0000_0000}); // default
    v.push_back('{5'h18, 32'd5,        32'd6,        32'h0000_0000}); // default
    foreach (v[i]) begin
      run_op(v[i].op, v[i].a, v[i].b);
      n_cmp++; if (!(got && lat == 0)) begin
        $display("FAIL legacy%0d_latency: got done=%b lat=%0d want done=1 lat=0", i, got, lat);
        n_err++;
      end
      n_cmp++; if (s !== v[i].r) begin
        $display("FAIL legacy%0d_s: got %h want %h", i, s, v[i].r); n_err++;
      end
      n_cmp++; if (z !== (v[i].r == 32'h0)) begin
        $display("FAIL legacy%0d_z: got %b want %b", i, z, (v[i].r == 32'h0)); n_err++;
      end
      n_cmp++; if (busy_cnt != 0 || busy !== 1'b0) begin
        $display("FAIL legacy%0d_busy: got %0d cycles want 0", i, busy_cnt); n_err++;
      end
    end
  endtask

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] h;
    logic [31:0] l;
  } mvec_t;

  task automatic test_muldiv();
    mvec_t v[$];
    v.push_back('{5'h11, 32'hffff_fffd, 32'd5, 32'hffff_ffff, 32'hffff_fff1}); // MULT -3*5
    v.push_back('{5'h10, 32'hffff_ffff, 32'hffff_ffff, 32'hffff_fffe, 32'h0000_0001});
    v.push_back('{5'h10, 32'd0, 32'd5, 32'h0, 32'h0});                         // zero product
    v.push_back('{5'h12, 32'd100, 32'd7, 32'd2, 32'd14});                      // DIVU
    v.push_back('{5'h13, 32'hffff_fff9, 32'd2, 32'hffff_ffff, 32'hffff_fffd}); // DIV -7/2
    v.push_back('{5'h13, 32'd7, 32'hffff_fffe, 32'h0000_0001, 32'hffff_fffd}); // DIV 7/-2
    v.push_back('{5'h13, 32'h8000_0000, 32'hffff_ffff, 32'h0, 32'h8000_0000}); // MIN/-1
    foreach (v[i]) begin
      run_op(v[i].op, v[i].a, v[i].b);
      n_cmp++; if (!(got && lat == 33)) begin
        $display("FAIL md%0d_latency: got done=%b lat=%0d want done=1 lat=33", i, got, lat);
        n_err++;
      end
      n_cmp++; if (busy_cnt != 33 || busy !== 1'b0) begin
        $display("FAIL md%0d_busy: got %0d cycles busy_now=%b want 33/0", i, busy_cnt, busy);
        n_err++;
      end
      n_cmp++; if ({hi, lo} !== {v[i].h, v[i].l}) begin
        $display("FAIL md%0d_hilo: got %h_%h want %h_%h", i, hi, lo, v[i].h, v[i].l);
        n_err++;
      end
      n_cmp++; if (s !== v[i].l || z !== (v[i].l == 32'h0) || dz !== 1'b0) begin
        $display("FAIL md%0d_s_z_dz: got %h %b %b want %h %b 0", i, s, z, dz,
                 v[i].l, (v[i].l == 32'h0));
        n_err++;
      end
      @(posedge clk); #1;
      n_cmp++; if (done !== 1'b0) begin
        $display("FAIL md%0d_done_pulse: got %b want 0", i, done); n_err++;
      end
    end
  endtask

  task automatic test_divzero();
    run_op(5'h12, 32'd9, 32'd0);
    n_cmp++; if (!(got && lat == 1 && busy_cnt == 1)) begin
      $display("FAIL dz_latency: got done=%b lat=%0d busy=%0d want 1/1/1", got, lat, busy_cnt);
      n_err++;
    end
    n_cmp++; if ({hi, lo, dz} !== {32'd9, 32'hffff_ffff, 1'b1}) begin
      $display("FAIL dz_result: got hi=%h lo=%h dz=%b want 9 ffffffff 1", hi, lo, dz); n_err++;
    end
    // Issued while done is still high: back-to-back acceptance
    run_op(5'h00, 32'd3, 32'd4);
    n_cmp++; if (!(got && lat == 0) || s !== 32'd7 || dz !== 1'b0) begin
      $display("FAIL dz_clear: got s=%h dz=%b lat=%0d want 7 0 0", s, dz, lat); n_err++;
    end
    n_cmp++; if ({hi, lo} !== {32'd9, 32'hffff_ffff}) begin
      $display("FAIL legacy_holds_hilo: got %h_%h want 00000009_ffffffff", hi, lo); n_err++;
    end
    run_op(5'h13, 32'hffff_fff9, 32'd0);
    n_cmp++; if (!(got && lat == 1) || {hi, lo, dz} !== {32'hffff_fff9, 32'hffff_ffff, 1'b1}) begin
      $display("FAIL dz_signed: got hi=%h lo=%h dz=%b lat=%0d want fffffff9 ffffffff 1 1",
               hi, lo, dz, lat);
      n_err++;
    end
  endtask

  task automatic test_hazard_start();
    @(negedge clk);
    start = 1'b1; aluc = 5'h11; a = 32'd7; b = 32'hffff_fffa;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 100) begin
      if (lat == 5) begin start = 1'b1; aluc = 5'h00; a = 32'd1; b = 32'd1; end
      else start = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    n_cmp++; if (!(done && lat == 33)) begin
      $display("FAIL hazard_start_latency: got done=%b lat=%0d want 1 33", done, lat); n_err++;
    end
    n_cmp++; if ({hi, lo, s} !== {32'hffff_ffff, 32'hffff_ffd6, 32'hffff_ffd6}) begin
      $display("FAIL hazard_start_result: got %h %h %h want ffffffff ffffffd6 ffffffd6",
               hi, lo, s);
      n_err++;
    end
  endtask

  task automatic test_hazard_reset();
    int dcnt;
    @(negedge clk);
    start = 1'b1; aluc = 5'h10; a = 32'd1234; b = 32'd5678;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin @(posedge clk); #1; end
    n_cmp++; if (busy !== 1'b1) begin
      $display("FAIL hazard_reset_busy: got %b want 1", busy); n_err++;
    end
    #2 clrn = 1'b0;
    #1;
    n_cmp++; if ({s, z, hi, lo, busy, done, dz} !== {32'h0, 1'b1, 64'h0, 3'b000}) begin
      $display("FAIL hazard_reset_outputs: got s=%h z=%b hi=%h lo=%h b/d/dz=%b", s, z, hi, lo,
               {busy, done, dz});
      n_err++;
    end
    dcnt = 0;
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; if (done) dcnt++; end
    @(negedge clk); clrn = 1'b1;
    for (int i = 0; i < 40; i++) begin @(posedge clk); #1; if (done || busy) dcnt++; end
    n_cmp++; if (dcnt != 0) begin
      $display("FAIL hazard_reset_no_done: got %0d done/busy cycles want 0", dcnt); n_err++;
    end
    run_op(5'h00, 32'd2, 32'd3);
    n_cmp++; if (!(got && lat == 0) || s !== 32'd5) begin
      $display("FAIL post_reset_add: got s=%h lat=%0d want 5 0", s, lat); n_err++;
    end
    run_op(5'h10, 32'd3, 32'd4);
    n_cmp++; if (!(got && lat == 33) || {hi, lo} !== {32'h0, 32'd12}) begin
      $display("FAIL post_reset_multu: got %h_%h lat=%0d want 0_c 33", hi, lo, lat); n_err++;
    end
  endtask

  task automatic test_width8();
    logic [4:0]  ops[7];
    logic [7:0]  xs[7];
    logic [7:0]  ys[7];
    logic [15:0] e;
    int          el;
    ops = '{5'h11, 5'h10, 5'h12, 5'h13, 5'h13, 5'h12, 5'h13};
    xs  = '{8'hfd, 8'hff, 8'h64, 8'hf9, 8'h80, 8'h09, 8'hf9};
    ys  = '{8'h05, 8'hff, 8'h07, 8'h02, 8'hff, 8'h00, 8'h00};
    for (int i = 0; i < 7; i++) begin
      e  = ref8(ops[i], xs[i], ys[i]);
      el = (ops[i][1] && ys[i] == 8'h00) ? 1 : 9;
      run_op8(ops[i], xs[i], ys[i]);
      n_cmp++; if (!(got && lat == el)) begin
        $display("FAIL w8_%0d_latency: got done=%b lat=%0d want 1 %0d", i, got, lat, el);
        n_err++;
      end
      n_cmp++; if ({hi8, lo8} !== e || s8 !== e[7:0]) begin
        $display("FAIL w8_%0d_hilo: got %h_%h s=%h want %h", i, hi8, lo8, s8, e); n_err++;
      end
      n_cmp++; if (dz8 !== (el == 1) || busy8 !== 1'b0) begin
        $display("FAIL w8_%0d_dz_busy: got %b %b want %b 0", i, dz8, busy8, (el == 1));
        n_err++;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    start = 1'b0; aluc = 5'h0; a = '0; b = '0;
    start8 = 1'b0; aluc8 = 5'h0; a8 = '0; b8 = '0;
    test_reset();
    test_legacy();
    test_muldiv();
    test_divzero();
    test_hazard_start();
    test_hazard_reset();
    test_width8();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
